// File: rtl/twin_tx_pkg.sv
// Shared state encoding, line levels and sizing helpers for the twin-byte
// serial transmitter.
package twin_tx_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    START = 3'd1,
    DATA1 = 3'd2,
    DATA2 = 3'd3,
    STOP  = 3'd4
  } tx_state_t;

  localparam int DEFAULT_DATA_W = 8;
  localparam int FRAME_BITS     = 2 * DEFAULT_DATA_W + 2;

  localparam logic LINE_IDLE = 1'b1;
  localparam logic START_BIT = 1'b0;
  localparam logic STOP_BIT  = 1'b1;

  // A counter for n values needs at least one bit even when n is 1.
  function automatic int counter_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/tx_bit_timer.sv
// Baud counter: holds each serial bit for CLKS_PER_BIT clocks and flags the
// last cycle of every bit period while enabled.
module tx_bit_timer
  import twin_tx_pkg::*;
#(
  parameter int CLKS_PER_BIT = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic enable,
  output logic bit_tick
);

  localparam int CNT_W = counter_width(CLKS_PER_BIT);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(CLKS_PER_BIT - 1);

  logic [CNT_W-1:0] count;

  // Held at zero while idle so every frame starts on a fresh bit period.
  always_ff @(posedge clk) begin
    if (rst) begin
      count <= '0;
    end else if (!enable || count == LAST) begin
      count <= '0;
    end else begin
      count <= count + 1'b1;
    end
  end

  assign bit_tick = enable && (count == LAST);

endmodule

// File: rtl/twin_byte_serial_tx.sv
// Captures a (d1, d2) byte pair and sends it as one frame: start bit,
// d1 LSB-first, d2 LSB-first, stop bit.
module twin_byte_serial_tx
  import twin_tx_pkg::*;
#(
  parameter int DATA_W       = 8,
  parameter int CLKS_PER_BIT = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] d1,
  input  logic [DATA_W-1:0] d2,
  input  logic              load_valid,
  output logic              load_ready,
  output logic              tx_out,
  output logic              busy,
  output logic              done
);

  if (CLKS_PER_BIT < 1) begin : g_bad_clks_per_bit
    $error("twin_byte_serial_tx: CLKS_PER_BIT must be at least 1");
  end

  localparam int IDX_W = counter_width(DATA_W);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DATA_W - 1);

  tx_state_t         state;
  logic [IDX_W-1:0]  bit_idx;
  logic [DATA_W-1:0] shift1;
  logic [DATA_W-1:0] shift2;
  logic              bit_tick;

  tx_bit_timer #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_bit_timer (
    .clk     (clk),
    .rst     (rst),
    .enable  (state != IDLE),
    .bit_tick(bit_tick)
  );

  assign load_ready = (state == IDLE);

  // tx_out is loaded one edge ahead with the next bit, so each shift register
  // always presents the upcoming bit in position 0.
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      tx_out  <= LINE_IDLE;
      busy    <= 1'b0;
      done    <= 1'b0;
      bit_idx <= '0;
      shift1  <= '0;
      shift2  <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (load_valid && load_ready) begin
            shift1  <= d1;
            shift2  <= d2;
            bit_idx <= '0;
            tx_out  <= START_BIT;
            busy    <= 1'b1;
            state   <= START;
          end
        end

        START: begin
          if (bit_tick) begin
            tx_out <= shift1[0];
            shift1 <= shift1 >> 1;
            state  <= DATA1;
          end
        end

        DATA1: begin
          if (bit_tick) begin
            if (bit_idx == LAST_IDX) begin
              bit_idx <= '0;
              tx_out  <= shift2[0];
              shift2  <= shift2 >> 1;
              state   <= DATA2;
            end else begin
              bit_idx <= bit_idx + 1'b1;
              tx_out  <= shift1[0];
              shift1  <= shift1 >> 1;
            end
          end
        end

        DATA2: begin
          if (bit_tick) begin
            if (bit_idx == LAST_IDX) begin
              bit_idx <= '0;
              tx_out  <= STOP_BIT;
              state   <= STOP;
            end else begin
              bit_idx <= bit_idx + 1'b1;
              tx_out  <= shift2[0];
              shift2  <= shift2 >> 1;
            end
          end
        end

        STOP: begin
          if (bit_tick) begin
            tx_out <= LINE_IDLE;
            busy   <= 1'b0;
            done   <= 1'b1;
            state  <= IDLE;
          end
        end

        default: begin
          tx_out <= LINE_IDLE;
          busy   <= 1'b0;
          state  <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_twin_byte_serial_tx.sv
// Bench for twin_byte_serial_tx: one instance at 4 clocks/bit and one at
// 1 clock/bit, checked against a frame-level model plus fixed vectors.
module tb_twin_byte_serial_tx;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] d1 [2];
  logic [7:0] d2 [2];
  logic       lv [2];
  logic       ready [2];
  logic       tx [2];
  logic       busy [2];
  logic       done [2];

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  twin_byte_serial_tx #(.DATA_W(8), .CLKS_PER_BIT(4)) u_dut4 (
    .clk(clk), .rst(rst), .d1(d1[0]), .d2(d2[0]), .load_valid(lv[0]),
    .load_ready(ready[0]), .tx_out(tx[0]), .busy(busy[0]), .done(done[0])
  );

  twin_byte_serial_tx #(.DATA_W(8), .CLKS_PER_BIT(1)) u_dut1 (
    .clk(clk), .rst(rst), .d1(d1[1]), .d2(d2[1]), .load_valid(lv[1]),
    .load_ready(ready[1]), .tx_out(tx[1]), .busy(busy[1]), .done(done[1])
  );

  typedef struct {
    string      name;
    int         dut;
    logic [7:0] a;
    logic [7:0] b;
    logic [17:0] bits;
    bit         churn;
  } vec_t;

  vec_t tbl [4];

  task automatic checkOutput(input string name, input int actual, input int expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0d, expected %0d at %0t", name, actual, expected, $time);
    end
  endtask

  task automatic applyStimulus(input int i, input logic v, input logic [7:0] a, input logic [7:0] b);
    @(posedge clk);
    #1;
    lv[i] = v;
    d1[i] = a;
    d2[i] = b;
  endtask

  // Frame-level reference: a frame is 18 bits, each held cpb cycles, and the
  // line returns high with a done pulse once 18*cpb cycles have elapsed.
  int          cpb [2] = '{4, 1};
  bit          m_active [2] = '{0, 0};
  int          m_t [2] = '{0, 0};
  logic [17:0] m_frame [2];
  bit          m_done [2] = '{0, 0};
  bit          started = 0;

  always @(posedge clk) begin
    started = 1;
    for (int i = 0; i < 2; i++) begin
      m_done[i] = 0;
      if (rst) begin
        m_active[i] = 0;
        m_t[i] = 0;
      end else if (m_active[i]) begin
        m_t[i]++;
        if (m_t[i] == 18 * cpb[i]) begin
          m_active[i] = 0;
          m_done[i] = 1;
        end
      end else if (lv[i]) begin
        m_active[i] = 1;
        m_t[i] = 0;
        m_frame[i] = {1'b1, d2[i], d1[i], 1'b0};
      end
    end
  end

  always @(negedge clk) begin
    if (started) begin
      for (int i = 0; i < 2; i++) begin
        checkOutput($sformatf("model_tx%0d", i), tx[i],
                    m_active[i] ? int'(m_frame[i][m_t[i] / cpb[i]]) : 1);
        checkOutput($sformatf("model_busy%0d", i), busy[i], int'(m_active[i]));
        checkOutput($sformatf("model_ready%0d", i), ready[i], int'(!m_active[i]));
        checkOutput($sformatf("model_done%0d", i), done[i], int'(m_done[i]));
      end
    end
  end

  task automatic waitIdle(input int i);
    for (int n = 0; n < 200; n++) begin
      @(negedge clk);
      if (!busy[i]) return;
    end
    checkOutput($sformatf("idle_timeout%0d", i), 0, 1);
  endtask

  task automatic runFrame(input vec_t v);
    int c;
    c = cpb[v.dut];
    applyStimulus(v.dut, 1'b1, v.a, v.b);
    @(posedge clk);
    #1;
    if (v.churn) begin
      lv[v.dut] = 1'b1;
      d1[v.dut] = 8'hFF;
      d2[v.dut] = 8'hFF;
    end else begin
      lv[v.dut] = 1'b0;
    end
    for (int j = 0; j < 18 * c; j++) begin
      @(negedge clk);
      checkOutput($sformatf("%s_bit%0d", v.name, j / c), tx[v.dut], int'(v.bits[j / c]));
      checkOutput($sformatf("%s_busy", v.name), busy[v.dut], 1);
      checkOutput($sformatf("%s_ready", v.name), ready[v.dut], 0);
      checkOutput($sformatf("%s_early_done", v.name), done[v.dut], 0);
    end
    @(negedge clk);
    checkOutput($sformatf("%s_done", v.name), done[v.dut], 1);
    checkOutput($sformatf("%s_end_busy", v.name), busy[v.dut], 0);
    checkOutput($sformatf("%s_end_tx", v.name), tx[v.dut], 1);
    if (v.churn) begin
      @(negedge clk);
      checkOutput($sformatf("%s_recapture_busy", v.name), busy[v.dut], 1);
      checkOutput($sformatf("%s_recapture_start", v.name), tx[v.dut], 0);
      lv[v.dut] = 1'b0;
    end
    waitIdle(v.dut);
  endtask

  initial begin
    #600000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    int hi_run;
    int gap;
    int seen;

    tbl[0] = '{"a5_3c", 0, 8'hA5, 8'h3C, 18'b100111100101001010, 1'b0};
    tbl[1] = '{"a5_3c_churn", 0, 8'hA5, 8'h3C, 18'b100111100101001010, 1'b1};
    tbl[2] = '{"cpb1_5a_c3", 1, 8'h5A, 8'hC3, 18'b111000011010110100, 1'b0};
    tbl[3] = '{"post_rst_01_80", 0, 8'h01, 8'h80, 18'b110000000000000010, 1'b0};

    // Reset held with load_valid high must not start a frame.
    rst = 1'b1;
    for (int i = 0; i < 2; i++) begin
      lv[i] = 1'b1;
      d1[i] = 8'h96;
      d2[i] = 8'h69;
    end
    repeat (2) begin
      @(negedge clk);
      for (int i = 0; i < 2; i++) begin
        checkOutput("rst_tx", tx[i], 1);
        checkOutput("rst_ready", ready[i], 1);
        checkOutput("rst_busy", busy[i], 0);
        checkOutput("rst_done", done[i], 0);
      end
    end
    @(posedge clk);
    #1;
    rst = 1'b0;
    lv[0] = 1'b0;
    lv[1] = 1'b0;
    @(negedge clk);
    checkOutput("post_rst_idle", busy[0], 0);

    for (int n = 0; n < 3; n++) runFrame(tbl[n]);

    // Back-to-back frames with load_valid held high throughout.
    applyStimulus(0, 1'b1, 8'hFF, 8'h00);
    @(posedge clk);
    #1;
    d1[0] = 8'h00;
    d2[0] = 8'hFF;
    hi_run = 0;
    for (int j = 0; j < 72; j++) begin
      @(negedge clk);
      if (j >= 68 && tx[0]) hi_run++;
    end
    @(negedge clk);
    checkOutput("b2b_done1", done[0], 1);
    if (tx[0]) hi_run++;
    @(negedge clk);
    checkOutput("b2b_start2", tx[0], 0);
    checkOutput("b2b_high_run", hi_run, 5);
    lv[0] = 1'b0;
    gap = 1;
    seen = 0;
    for (int n = 0; n < 200 && !seen; n++) begin
      @(negedge clk);
      gap++;
      if (done[0]) seen = 1;
    end
    checkOutput("b2b_done2_seen", seen, 1);
    checkOutput("b2b_done_gap", gap, 73);
    waitIdle(0);

    // Reset while the second byte is on the line abandons the frame.
    applyStimulus(0, 1'b1, 8'hC7, 8'h2E);
    @(posedge clk);
    #1;
    lv[0] = 1'b0;
    repeat (50) @(posedge clk);
    #1;
    checkOutput("mid_busy_before_rst", busy[0], 1);
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    checkOutput("mid_rst_tx", tx[0], 1);
    checkOutput("mid_rst_busy", busy[0], 0);
    checkOutput("mid_rst_ready", ready[0], 1);
    checkOutput("mid_rst_done", done[0], 0);
    seen = 0;
    repeat (80) begin
      @(negedge clk);
      if (done[0]) seen++;
    end
    checkOutput("mid_rst_no_done", seen, 0);
    runFrame(tbl[3]);

    // Random traffic and occasional resets on both instances.
    for (int n = 0; n < 2000; n++) begin
      @(posedge clk);
      #1;
      rst = ($urandom_range(0, 299) == 0);
      for (int i = 0; i < 2; i++) begin
        lv[i] = ($urandom_range(0, 3) == 0);
        d1[i] = 8'($urandom);
        d2[i] = 8'($urandom);
      end
    end
    @(posedge clk);
    #1;
    rst = 1'b0;
    lv[0] = 1'b0;
    lv[1] = 1'b0;
    repeat (100) @(posedge clk);
    @(negedge clk);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
